// File: rtl/mt_fc_pkg.sv
// mt_fc_pkg -- shared definitions for the MT frame counter.
//   fc_state_t : termination-control states (IDLE, RUN, TERM)
//   fc_field() : extracts the low 'width' bits of bus data as the count field
//   FCE_*      : bit positions of the individual frame-count-error causes
package mt_fc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        TERM = 2'd2
    } fc_state_t;

    // Error causes; mtFCE is the sticky OR of these.
    localparam int unsigned FCE_WR_BUSY   = 0;  // write while operation armed
    localparam int unsigned FCE_UNDERFLOW = 1;  // decrement from zero
    localparam int unsigned FCE_OVERRUN   = 2;  // forward frame during TERM
    localparam int unsigned FCE_REST_BUSY = 3;  // restore while operation armed
    localparam int unsigned FCE_CAUSES    = 4;

    // Count field of a bus word: bits [width-1:0], zero-extended to 32 bits.
    function automatic logic [31:0] fc_field(input logic [63:0] data,
                                             input int unsigned width);
        logic [63:0] mask;
        mask = (64'd1 << width) - 64'd1;
        return 32'(data & mask);
    endfunction

endpackage

// File: rtl/mt_frame_counter.sv
// mt_frame_counter -- MT tape frame counter with termination control.
// Loaded with a two's-complement frame count, counts up on forward frames and
// down on backward frames, terminates an armed operation when an increment
// wraps the count to zero, and keeps a sticky count-error flag.
//
// Ports:
//   clk, rst   clock; asynchronous active-high reset
//   mtDATAI    bus write data, count in [WIDTH-1:0]
//   mtWRFC     write frame count
//   mtSTART    arm operation (pulse)      mtABORT  abort armed operation
//   mtINCFC    forward frame strobe       mtDECFC  backward frame strobe
//   mtCLRFCE   clear frame count error
//   mtRESTFC   restore count from shadow (MT_FC_SHADOW_EN only; tie 0 otherwise)
//   mtFC       current count              mtFCZ    mtFC == 0 (combinational)
//   mtBUSY     operation armed            mtDONE   one-cycle termination pulse
//   mtFCE      sticky frame count error
//
// Build option: define MT_FC_SHADOW_EN to add the shadow/restore register.
module mt_frame_counter
    import mt_fc_pkg::*;
#(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned DATA_WIDTH = 36
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] mtDATAI,
    input  logic                  mtWRFC,
    input  logic                  mtSTART,
    input  logic                  mtABORT,
    input  logic                  mtINCFC,
    input  logic                  mtDECFC,
    input  logic                  mtCLRFCE,
    input  logic                  mtRESTFC,
    output logic [WIDTH-1:0]      mtFC,
    output logic                  mtFCZ,
    output logic                  mtBUSY,
    output logic                  mtDONE,
    output logic                  mtFCE
);

    fc_state_t              state, state_nxt;
    logic [WIDTH-1:0]       fc, fc_nxt;
    logic                   fce, fce_nxt;
    logic [WIDTH-1:0]       wr_val;
    logic [WIDTH-1:0]       shadow_val;
    logic                   wr_ok;
    logic                   rest_ok;
    logic                   rest_err;
    logic                   inc_only;
    logic                   dec_only;
    logic                   step_ok;
    logic                   term_hit;
    logic [FCE_CAUSES-1:0]  cause;

    assign wr_val   = WIDTH'(fc_field(64'(mtDATAI), WIDTH));
    // An abort makes the same-cycle write behave as if already idle.
    assign wr_ok    = mtWRFC && ((state == IDLE) || mtABORT);
    assign inc_only = mtINCFC && !mtDECFC;
    assign dec_only = mtDECFC && !mtINCFC;
    // Frame strobes only move the count when no load has priority this cycle.
    assign step_ok  = !wr_ok && !rest_ok;
    assign term_hit = (state == RUN) && !mtABORT && step_ok && inc_only &&
                      (fc == '1);

`ifdef MT_FC_SHADOW_EN
    logic [WIDTH-1:0] shadow;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow <= '0;
        end else if (wr_ok) begin
            shadow <= wr_val;
        end
    end

    assign shadow_val = shadow;
    assign rest_ok    = mtRESTFC && (state == IDLE);
    assign rest_err   = mtRESTFC && (state != IDLE);
`else
    logic unused_restfc;
    assign unused_restfc = mtRESTFC;
    assign shadow_val    = '0;
    assign rest_ok       = 1'b0;
    assign rest_err      = 1'b0;
`endif

    // State / count / error register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            fc    <= '0;
            fce   <= 1'b0;
        end else begin
            state <= state_nxt;
            fc    <= fc_nxt;
            fce   <= fce_nxt;
        end
    end

    // Next-state, count and error logic.
    always_comb begin
        state_nxt = state;
        fc_nxt    = fc;
        cause     = '0;

        case (state)
            IDLE:    if (mtSTART) state_nxt = RUN;
            RUN:     if (term_hit) state_nxt = TERM;
            TERM:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (mtABORT) state_nxt = IDLE;

        if (wr_ok) begin
            fc_nxt = wr_val;
        end else if (rest_ok) begin
            fc_nxt = shadow_val;
        end else if (inc_only) begin
            fc_nxt = fc + WIDTH'(1);
        end else if (dec_only) begin
            fc_nxt = fc - WIDTH'(1);
        end

        cause[FCE_WR_BUSY]   = mtWRFC && !wr_ok;
        cause[FCE_UNDERFLOW] = step_ok && dec_only && (fc == '0);
        cause[FCE_OVERRUN]   = step_ok && inc_only && (state == TERM);
        cause[FCE_REST_BUSY] = rest_err;

        // Set wins over a simultaneous clear.
        if (|cause) begin
            fce_nxt = 1'b1;
        end else if (mtCLRFCE) begin
            fce_nxt = 1'b0;
        end else begin
            fce_nxt = fce;
        end
    end

    // Output decode.
    always_comb begin
        mtFC   = fc;
        mtFCZ  = (fc == '0);
        mtBUSY = (state != IDLE);
        mtDONE = (state == TERM);
        mtFCE  = fce;
    end

endmodule

// File: doc/mt_frame_counter.md
Name: mt_frame_counter

Overview:
- Parametrised successor to the single-width MT frame count register: a frame counter with termination control for the MT (TM03-style) tape datapath.
- Loaded with the two's-complement frame count from the bus. Counts up on forward frames and down on backward frames.
- Tracks an armed transfer/space operation; terminates it when the count reaches zero and flags count errors.
- Sits between the MT register decode (write strobes, bus data) and the tape transfer sequencer (frame strobes, start/abort).

Parameters:
- WIDTH, 16, frame count width in bits (2..32).
- DATA_WIDTH, 36, bus data width; WIDTH <= DATA_WIDTH.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- mtDATAI  in  DATA_WIDTH  bus write data; count taken from bits [WIDTH-1:0]
- mtWRFC  in  1  write frame count
- mtSTART  in  1  arm operation (single-cycle pulse)
- mtABORT  in  1  abort armed operation
- mtINCFC  in  1  forward frame strobe
- mtDECFC  in  1  backward frame strobe
- mtCLRFCE  in  1  clear frame count error
- mtRESTFC  in  1  restore shadow count (only with MT_FC_SHADOW_EN; tie 0 otherwise)
- mtFC  out  WIDTH  current frame count
- mtFCZ  out  1  mtFC == 0 (combinational)
- mtBUSY  out  1  operation armed (state RUN or TERM)
- mtDONE  out  1  one-cycle termination pulse
- mtFCE  out  1  sticky frame count error

Behaviour:
- Reset (async, any time, including mid-operation):
  - mtFC=0, state=IDLE, mtBUSY=0, mtDONE=0, mtFCE=0, shadow=0.
  - mtFCZ=1 as a consequence.
- Registered outputs: every output except mtFCZ updates on the clk edge after the cause (1-cycle latency).
- States: IDLE, RUN, TERM. mtBUSY = (state != IDLE); mtDONE = (state == TERM).
- IDLE:
  - mtWRFC loads mtFC <= mtDATAI[WIDTH-1:0].
  - mtINCFC / mtDECFC modify the count (diagnostic) with no termination.
  - mtSTART -> RUN.
- RUN:
  - mtINCFC: mtFC+1 mod 2^WIDTH. If the result is 0 (mtFC was all ones) -> TERM.
  - mtDECFC: mtFC-1 mod 2^WIDTH. Never terminates.
  - mtSTART is ignored.
  - mtWRFC is ignored; mtFC is unchanged and mtFCE is set.
- TERM: lasts exactly one cycle, then -> IDLE. mtINCFC in TERM still counts and sets mtFCE (overrun).
- Start with mtFC=0 means 2^WIDTH frames: termination only on the increment that wraps to zero, never on entry.
- Underflow: mtDECFC with mtFC=0 in any state gives all ones and sets mtFCE.
- mtINCFC and mtDECFC in the same cycle: count unchanged, no termination, no error.
- mtABORT:
  - Any state -> IDLE, count retained, no mtDONE.
  - mtINCFC/mtDECFC in the same cycle are still applied to the count.
  - mtWRFC in the same cycle is honoured as if in IDLE.
- Count-update priority: mtWRFC (when honoured) > mtRESTFC > mtINCFC/mtDECFC.
- mtFCE: set by the conditions above, cleared by mtCLRFCE. Set wins over a simultaneous clear.

Optional Feature:
- Macro MT_FC_SHADOW_EN.
- With it:
  - A WIDTH-bit shadow register captures mtDATAI[WIDTH-1:0] on every honoured mtWRFC.
  - mtRESTFC in IDLE reloads mtFC from the shadow, for retry after error.
  - mtRESTFC in RUN/TERM is ignored and sets mtFCE.
- Without it: no shadow register; mtRESTFC is ignored entirely.

Decomposition:
- Package mt_fc_pkg:
  - state enum (IDLE, RUN, TERM)
  - function extracting the count field from bus data, parametrised by WIDTH
  - error-cause constants
- No sub-module: a single always_ff plus next-state logic.

Test Plan:
- Reset then write 0o177775 (-3, WIDTH=16), START, 3x INCFC -> mtFC 0o177776, 0o177777, 0; mtDONE high exactly one cycle after the 3rd INC; mtBUSY drops the following cycle.
- Write 0, START, 65536 INCFC -> mtDONE only after the 65536th strobe; no early termination at start.
- RUN with mtFC=5: WRFC 0o1234 -> mtFC stays 5, mtFCE=1; CLRFCE with DECFC from 0 in the same cycle -> mtFCE stays 1.
- Same-cycle INC+DEC at mtFC=0o177777 in RUN -> count unchanged, no TERM; ABORT next cycle -> IDLE, mtFC=0o177777, no mtDONE.
- Assert rst asynchronously mid-RUN (between edges) -> all outputs reset immediately; mtFCZ=1.
- With MT_FC_SHADOW_EN: write 0o177770, 4x INC in IDLE (mtFC=0o177774), RESTFC -> mtFC=0o177770; RESTFC during RUN -> count unchanged, mtFCE=1.
